// File: rtl/mp3_cmd_sched.sv
// MP3 player command scheduler: captures panel request edges, arbitrates
// by fixed priority and streams 7E..EF frames over a valid/ready link.
module mp3_cmd_sched #(
  parameter int GAP_CYC = 500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [8:0] req_trk,
  input  logic [5:0] req_fn,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       cmd_done,
  output logic [3:0] cur_cmd
);

  localparam int GW = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;
  localparam logic [GW-1:0] GAP_LAST =
    (GAP_CYC > 0) ? GW'(GAP_CYC - 1) : '0;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP
  } state_t;

  state_t        state_q;
  logic [14:0]   pend_q;
  logic [14:0]   prev_q;
  logic [47:0]   frame_q;
  logic [2:0]    len_q;
  logic [2:0]    idx_q;
  logic [GW-1:0] gap_q;
  logic [7:0]    tx_data_q;
  logic          tx_valid_q;
  logic          cmd_done_q;
  logic [3:0]    cur_q;

  logic [14:0]   req_all;
  logic [14:0]   rise;
  logic [14:0]   gnt_mask;
  logic [3:0]    gidx;
  logic          any;
  logic [47:0]   frame_d;
  logic [2:0]    len_d;
  logic [7:0]    fn_code;
  logic          accept;
  logic          last;

  always_comb begin
    req_all = {req_fn, req_trk};
    rise    = req_all & ~prev_q;
    any     = |pend_q;
    // descending scan leaves the lowest set index as winner
    gidx    = 4'd0;
    for (int i = 14; i >= 0; i--) begin
      if (pend_q[i]) gidx = 4'(i);
    end
    gnt_mask = '0;
    if (state_q == IDLE && any) gnt_mask[gidx] = 1'b1;
    fn_code = 8'h04;
    case (gidx)
      4'd9:    fn_code = 8'h01;
      4'd10:   fn_code = 8'h02;
      4'd11:   fn_code = 8'h05;
      4'd12:   fn_code = 8'h06;
      4'd13:   fn_code = 8'h03;
      default: fn_code = 8'h04;
    endcase
    if (gidx < 4'd9) begin
      len_d   = 3'd6;
      frame_d = {8'h7E, 8'h04, 8'h45, 8'h00,
                 4'h0, gidx + 4'd1, 8'hEF};
    end else begin
      len_d   = 3'd4;
      frame_d = {8'h7E, 8'h02, fn_code, 8'hEF, 16'h0000};
    end
    accept = tx_valid_q & tx_ready;
    last   = (idx_q == len_q - 3'd1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pend_q     <= '0;
      prev_q     <= '1;
      frame_q    <= '0;
      len_q      <= 3'd4;
      idx_q      <= 3'd0;
      gap_q      <= '0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      cmd_done_q <= 1'b0;
      cur_q      <= 4'd0;
    end else begin
      prev_q     <= req_all;
      // set wins over the grant clear
      pend_q     <= (pend_q & ~gnt_mask) | rise;
      cmd_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (any) begin
            state_q    <= SEND;
            frame_q    <= {frame_d[39:0], 8'h00};
            len_q      <= len_d;
            idx_q      <= 3'd0;
            cur_q      <= gidx;
            tx_data_q  <= frame_d[47:40];
            tx_valid_q <= 1'b1;
          end
        end
        SEND: begin
          if (accept) begin
            if (last) begin
              tx_valid_q <= 1'b0;
              cmd_done_q <= 1'b1;
              gap_q      <= '0;
              state_q    <= (GAP_CYC == 0) ? IDLE : GAP;
            end else begin
              idx_q     <= idx_q + 3'd1;
              tx_data_q <= frame_q[47:40];
              frame_q   <= {frame_q[39:0], 8'h00};
            end
          end
        end
        GAP: begin
          if (gap_q == GAP_LAST) state_q <= IDLE;
          else gap_q <= gap_q + GW'(1);
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign cmd_done = cmd_done_q;
  assign cur_cmd  = cur_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_mp3_cmd_sched.sv
// Scoreboard bench for mp3_cmd_sched: expected bytes are queued by the
// stimulus thread and popped by an independent monitor on transfers.
module tb_mp3_cmd_sched;

  logic       clk;
  logic       rst_n;
  logic [8:0] req_trk;
  logic [5:0] req_fn;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       cmd_done;
  logic [3:0] cur_cmd;

  mp3_cmd_sched #(.GAP_CYC(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_trk  (req_trk),
    .req_fn   (req_fn),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .busy     (busy),
    .cmd_done (cmd_done),
    .cur_cmd  (cur_cmd)
  );

  int checks = 0;
  int errors = 0;
  int acc_cnt = 0;
  int done_cnt = 0;
  bit rnd_mode = 0;
  logic [7:0] exp_q[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic push_trk(input int n);
    exp_q.push_back(8'h7E);
    exp_q.push_back(8'h04);
    exp_q.push_back(8'h45);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'(n));
    exp_q.push_back(8'hEF);
  endtask

  task automatic push_fn(input logic [7:0] code);
    exp_q.push_back(8'h7E);
    exp_q.push_back(8'h02);
    exp_q.push_back(code);
    exp_q.push_back(8'hEF);
  endtask

  task automatic wait_done(input int n, input string name);
    int seen;
    seen = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (cmd_done) seen++;
      if (seen == n) break;
    end
    chk(name, seen, n);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // ready driver: steady high or random
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      tx_ready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // monitor: transfer happens at the posedge following this negedge
  initial begin
    bit hold;
    logic [7:0] hold_d;
    logic [7:0] e;
    hold = 0;
    hold_d = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold = 0;
      end else begin
        if (hold) begin
          chk("hold_valid", int'(tx_valid), 1);
          chk("hold_data", int'(tx_data), int'(hold_d));
        end
        if (cmd_done) done_cnt++;
        if (tx_valid && tx_ready) begin
          acc_cnt++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_byte: got %0h expected none", tx_data);
          end else begin
            e = exp_q.pop_front();
            chk("byte", int'(tx_data), int'(e));
          end
        end
        hold = tx_valid && !tx_ready;
        hold_d = tx_data;
      end
    end
  end

  initial begin
    int n;
    int base;
    rst_n = 1'b0;
    req_trk = '0;
    req_fn = '0;
    #22;
    chk("rst_valid", int'(tx_valid), 0);
    chk("rst_data", int'(tx_data), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(cmd_done), 0);
    chk("rst_cur", int'(cur_cmd), 0);
    cyc();
    rst_n = 1'b1;
    repeat (3) cyc();

    // single track-3 request, latency and gap timing
    req_trk[2] = 1'b1;
    push_trk(3);
    cyc();
    req_trk[2] = 1'b0;
    @(negedge clk);
    chk("lat_k", int'(tx_valid), 0);
    cyc();
    @(negedge clk);
    chk("lat_k1_valid", int'(tx_valid), 1);
    chk("lat_k1_busy", int'(busy), 1);
    n = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      n++;
      if (cmd_done) break;
    end
    chk("frame_cycles", n, 6);
    chk("t1_cur", int'(cur_cmd), 2);
    chk("gap_busy0", int'(busy), 1);
    repeat (3) @(negedge clk);
    chk("gap_busy3", int'(busy), 1);
    @(negedge clk);
    chk("gap_busy_low", int'(busy), 0);
    repeat (4) cyc();

    // simultaneous track-1 and vol+
    req_fn[2] = 1'b1;
    req_trk[0] = 1'b1;
    push_trk(1);
    push_fn(8'h05);
    cyc();
    req_fn[2] = 1'b0;
    req_trk[0] = 1'b0;
    wait_done(2, "t2_done");
    chk("t2_cur", int'(cur_cmd), 11);
    repeat (10) cyc();

    // random back-pressure
    rnd_mode = 1;
    req_trk[8] = 1'b1;
    req_fn[5] = 1'b1;
    push_trk(9);
    push_fn(8'h04);
    cyc();
    req_trk[8] = 1'b0;
    req_fn[5] = 1'b0;
    wait_done(2, "t3_done");
    rnd_mode = 0;
    repeat (10) cyc();

    // request held high across reset release
    rst_n = 1'b0;
    #2;
    req_fn[1] = 1'b1;
    cyc();
    rst_n = 1'b1;
    repeat (20) cyc();
    chk("t4_no_frame", int'(busy), 0);
    chk("t4_q_empty", exp_q.size(), 0);
    req_fn[1] = 1'b0;
    cyc();
    req_fn[1] = 1'b1;
    push_fn(8'h02);
    cyc();
    req_fn[1] = 1'b0;
    wait_done(1, "t4_done");
    repeat (10) cyc();

    // merge of repeated edges while busy
    req_trk[0] = 1'b1;
    push_trk(1);
    push_trk(5);
    cyc();
    req_trk[0] = 1'b0;
    cyc();
    for (int k = 0; k < 3; k++) begin
      req_trk[4] = 1'b1;
      cyc();
      req_trk[4] = 1'b0;
      cyc();
    end
    wait_done(2, "t5_done");
    chk("t5_cur", int'(cur_cmd), 4);
    repeat (20) cyc();
    chk("t5_no_extra", int'(busy), 0);

    // reset mid-frame after the third byte
    base = acc_cnt;
    req_trk[1] = 1'b1;
    exp_q.push_back(8'h7E);
    exp_q.push_back(8'h04);
    exp_q.push_back(8'h45);
    cyc();
    req_trk[1] = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      #1;
      if (acc_cnt >= base + 3) break;
    end
    chk("t6_bytes", acc_cnt - base, 3);
    cyc();
    rst_n = 1'b0;
    #1;
    chk("t6_valid", int'(tx_valid), 0);
    chk("t6_busy", int'(busy), 0);
    chk("t6_done", int'(cmd_done), 0);
    cyc();
    rst_n = 1'b1;
    repeat (20) cyc();
    chk("t6_idle", int'(busy), 0);
    chk("t6_acc", acc_cnt - base, 3);

    chk("q_empty", exp_q.size(), 0);
    chk("done_total", done_cnt, 8);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
